// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: operand width, FUNC3 encodings and the
// multiply/divide sequencer state type.
package rv32m_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_divider.sv
// Restoring divider datapath on unsigned magnitudes: one quotient bit per
// step, 32 steps per division. Sign handling lives in the parent.
module muldiv_divider
    import rv32m_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic [4:0]      count
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dsr_q;
    logic [4:0]      cnt_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // The partial remainder stays below the divisor, so a 33-bit compare
    // suffices: diff[XLEN] set means the trial subtraction went negative.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dsr_q};
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_q <= cnt_q + 5'd1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign count     = cnt_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit for the EX stage: 2-cycle multiply, 33-cycle
// restoring divide, single-cycle DONE pulse with a held RESULT register.
//
// state | meaning
// IDLE  | waiting for START; DONE cycle of the previous op lands here
// MUL   | registering the 66-bit product
// DIV   | 32 restoring-division steps
// FIN   | sign fix and RESULT load; DONE follows
module muldiv_unit
    import rv32m_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    muldiv_state_t state_q, state_d;

    logic            accept, div_load, div_step, prod_load, fin_load;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_value;
    logic            in_signed;
    logic [XLEN-1:0] mag1, mag2;

    logic [2:0]         func3_q;
    logic [XLEN-1:0]    op1_q, op2_q;
    logic               special_q;
    logic [XLEN-1:0]    special_val_q;
    logic signed [65:0] product_q;
    logic [1:0]         unused_product_msbs;

    logic signed [32:0] mul_a, mul_b;
    logic [XLEN-1:0]    quotient, remainder, q_fix, r_fix, fin_value;
    logic [4:0]         count;
    logic               q_neg, r_neg;

    // Special-case detection and magnitude formation act on live inputs at accept.
    always_comb begin
        in_signed     = !FUNC3[0];
        div_zero      = (OPERAND2 == '0);
        div_ovf       = in_signed && (OPERAND1 == 32'h8000_0000) && (OPERAND2 == 32'hFFFF_FFFF);
        special       = FUNC3[2] && (div_zero || div_ovf);
        special_value = div_zero ? (FUNC3[1] ? OPERAND1 : '1)
                                 : (FUNC3[1] ? '0 : 32'h8000_0000);
        mag1          = (in_signed && OPERAND1[XLEN-1]) ? (~OPERAND1 + 1'b1) : OPERAND1;
        mag2          = (in_signed && OPERAND2[XLEN-1]) ? (~OPERAND2 + 1'b1) : OPERAND2;
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (FLUSH) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (START) begin
                    if (!FUNC3[2])    state_d = ST_MUL;
                    else if (special) state_d = ST_FIN;
                    else              state_d = ST_DIV;
                end
                ST_MUL:  state_d = ST_FIN;
                ST_DIV:  if (count == 5'd31) state_d = ST_FIN;
                ST_FIN:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        BUSY      = (state_q != ST_IDLE);
        accept    = (state_q == ST_IDLE) && START && !FLUSH;
        div_load  = accept && FUNC3[2] && !special;
        div_step  = (state_q == ST_DIV) && !FLUSH;
        prod_load = (state_q == ST_MUL) && !FLUSH;
        fin_load  = (state_q == ST_FIN) && !FLUSH;
    end

    muldiv_divider u_divider (
        .clk       (CLK),
        .rst       (RST),
        .clear     (FLUSH),
        .load      (div_load),
        .step      (div_step),
        .dividend  (mag1),
        .divisor   (mag2),
        .quotient  (quotient),
        .remainder (remainder),
        .count     (count)
    );

    // rs1 signed for MULH/MULHSU, rs2 signed for MULH only.
    always_comb begin
        mul_a = {(func3_q == F3_MULH || func3_q == F3_MULHSU) & op1_q[XLEN-1], op1_q};
        mul_b = {(func3_q == F3_MULH) & op2_q[XLEN-1], op2_q};
    end

    assign unused_product_msbs = product_q[65:64];

    always_comb begin
        q_neg = !func3_q[0] && (op1_q[XLEN-1] ^ op2_q[XLEN-1]);
        r_neg = !func3_q[0] && op1_q[XLEN-1];
        q_fix = q_neg ? (~quotient + 1'b1) : quotient;
        r_fix = r_neg ? (~remainder + 1'b1) : remainder;
        if (!func3_q[2])
            fin_value = (func3_q == F3_MUL) ? product_q[31:0] : product_q[63:32];
        else if (special_q)
            fin_value = special_val_q;
        else
            fin_value = func3_q[1] ? r_fix : q_fix;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            func3_q       <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            product_q     <= '0;
            RESULT        <= '0;
            DONE          <= 1'b0;
        end else begin
            DONE <= fin_load;
            if (accept) begin
                func3_q       <= FUNC3;
                op1_q         <= OPERAND1;
                op2_q         <= OPERAND2;
                special_q     <= special;
                special_val_q <= special_value;
            end
            if (prod_load) product_q <= mul_a * mul_b;
            if (fin_load)  RESULT    <= fin_value;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: result values, DONE latency, BUSY profile,
// flush, ignored start, mid-op reset and back-to-back issue.
module tb_muldiv_unit;
    import rv32m_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [2:0]  FUNC3 = 3'b000;
    logic [31:0] OPERAND1 = '0;
    logic [31:0] OPERAND2 = '0;
    logic        FLUSH = 1'b0;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_result = '0;

    always #5 CLK = ~CLK;

    muldiv_unit dut (
        .CLK(CLK), .RST(RST), .START(START), .FUNC3(FUNC3),
        .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .FLUSH(FLUSH),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    // Issues one op and measures it; comparisons are made by the callers.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output int busy_cycles,
                         output logic done_twice, output logic res_early);
        logic [31:0] r0;
        lat = -1; res = 'x; busy_cycles = 0; done_twice = 1'b0; res_early = 1'b0;
        @(negedge CLK);
        START = 1'b1; FUNC3 = f3; OPERAND1 = a; OPERAND2 = b;
        r0 = RESULT;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            if (k == 1) START = 1'b0;
            if (BUSY) busy_cycles++;
            if (DONE) begin
                lat = k;
                res = RESULT;
                break;
            end
            if (RESULT !== r0) res_early = 1'b1;
        end
        START = 1'b0;
        if (lat > 0) begin
            @(negedge CLK);
            done_twice = DONE;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", DONE); end
        n_checks++; if (RESULT !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", RESULT); end
        RST = 1'b0;
    endtask

    task automatic test_mul();
        int lat, bc; logic [31:0] res; logic dt, re;
        do_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, lat, res, bc, dt, re);
        n_checks++; if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result: got %h expected ffffffeb", res); end
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL mul_latency: got %0d expected 3", lat); end
        n_checks++; if (bc != 2) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected 2", bc); end
        n_checks++; if (dt !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse: got %b expected 0", dt); end
        last_result = 32'hFFFF_FFEB;
    endtask

    task automatic test_mul_high();
        int lat, bc; logic [31:0] res; logic dt, re;
        do_op(F3_MULH, 32'h8000_0000, 32'h8000_0000, lat, res, bc, dt, re);
        n_checks++; if (res !== 32'h4000_0000) begin n_fail++; $display("FAIL mulh_result: got %h expected 40000000", res); end
        do_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, bc, dt, re);
        n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_result: got %h expected fffffffe", res); end
        do_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, bc, dt, re);
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu_result: got %h expected ffffffff", res); end
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL mulhsu_latency: got %0d expected 3", lat); end
        last_result = 32'hFFFF_FFFF;
    endtask

    task automatic test_div();
        int lat, bc; logic [31:0] res; logic dt, re;
        do_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, lat, res, bc, dt, re);
        n_checks++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_result: got %h expected fffffffd", res); end
        n_checks++; if (lat != 34) begin n_fail++; $display("FAIL div_latency: got %0d expected 34", lat); end
        n_checks++; if (bc != 33) begin n_fail++; $display("FAIL div_busy_cycles: got %0d expected 33", bc); end
        n_checks++; if (re !== 1'b0) begin n_fail++; $display("FAIL div_result_early: got %b expected 0", re); end
        n_checks++; if (dt !== 1'b0) begin n_fail++; $display("FAIL div_done_pulse: got %b expected 0", dt); end
        do_op(F3_REM, 32'hFFFF_FFF9, 32'd2, lat, res, bc, dt, re);
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_result: got %h expected ffffffff", res); end
        do_op(F3_DIVU, 32'd100, 32'd7, lat, res, bc, dt, re);
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu_result: got %h expected 0000000e", res); end
        do_op(F3_REMU, 32'd100, 32'd7, lat, res, bc, dt, re);
        n_checks++; if (res !== 32'd2) begin n_fail++; $display("FAIL remu_result: got %h expected 00000002", res); end
        last_result = 32'd2;
    endtask

    task automatic test_special();
        int lat, bc; logic [31:0] res; logic dt, re;
        do_op(F3_DIVU, 32'h1234, 32'd0, lat, res, bc, dt, re);
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by_zero: got %h expected ffffffff", res); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL divu_by_zero_latency: got %0d expected 2", lat); end
        do_op(F3_REM, 32'h1234, 32'd0, lat, res, bc, dt, re);
        n_checks++; if (res !== 32'h1234) begin n_fail++; $display("FAIL rem_by_zero: got %h expected 00001234", res); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL rem_by_zero_latency: got %0d expected 2", lat); end
        do_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, bc, dt, re);
        n_checks++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL div_overflow: got %h expected 80000000", res); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL div_overflow_latency: got %0d expected 2", lat); end
        do_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, bc, dt, re);
        n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL rem_overflow: got %h expected 00000000", res); end
        n_checks++; if (bc != 1) begin n_fail++; $display("FAIL rem_overflow_busy_cycles: got %0d expected 1", bc); end
        last_result = 32'h0;
    endtask

    task automatic test_flush();
        int lat, bc, dones; logic [31:0] res; logic dt, re;
        @(negedge CLK);
        START = 1'b1; FUNC3 = F3_DIVU; OPERAND1 = 32'd100; OPERAND2 = 32'd7;
        for (int k = 1; k <= 11; k++) begin
            @(negedge CLK);
            if (k == 1) START = 1'b0;
        end
        FLUSH = 1'b1;   // divider is at iteration 10 in this cycle
        @(negedge CLK);
        FLUSH = 1'b0;
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", BUSY); end
        n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %b expected 0", DONE); end
        n_checks++; if (RESULT !== last_result) begin n_fail++; $display("FAIL flush_result_held: got %h expected %h", RESULT, last_result); end
        do_op(F3_MUL, 32'd6, 32'd7, lat, res, bc, dt, re);
        n_checks++; if (res !== 32'd42) begin n_fail++; $display("FAIL post_flush_mul: got %h expected 0000002a", res); end
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL post_flush_mul_latency: got %0d expected 3", lat); end
        last_result = 32'd42;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL flush_stray_done: got %0d pulses expected 0", dones); end
        @(negedge CLK);
        START = 1'b1; FLUSH = 1'b1; FUNC3 = F3_MUL;
        @(negedge CLK);
        START = 1'b0; FLUSH = 1'b0;
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_start: got busy %b expected 0", BUSY); end
    endtask

    task automatic test_ignored_start();
        int lat;
        logic [31:0] res;
        lat = -1; res = 'x;
        @(negedge CLK);
        START = 1'b1; FUNC3 = F3_DIVU; OPERAND1 = 32'd100; OPERAND2 = 32'd7;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            if (k == 1) START = 1'b0;
            if (k == 5) begin START = 1'b1; FUNC3 = F3_MUL; OPERAND1 = 32'd2; OPERAND2 = 32'd3; end
            if (k == 6) START = 1'b0;
            if (DONE) begin lat = k; res = RESULT; break; end
        end
        START = 1'b0;
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL ignored_start_result: got %h expected 0000000e", res); end
        n_checks++; if (lat != 34) begin n_fail++; $display("FAIL ignored_start_latency: got %0d expected 34", lat); end
        last_result = 32'd14;
    endtask

    task automatic test_rst_mid();
        @(negedge CLK);
        START = 1'b1; FUNC3 = F3_DIV; OPERAND1 = 32'hFFFF_FFF9; OPERAND2 = 32'd2;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            if (k == 1) START = 1'b0;
        end
        RST = 1'b1;     // divider is at iteration 5 in this cycle
        @(negedge CLK);
        RST = 1'b0;
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", BUSY); end
        n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", DONE); end
        n_checks++; if (RESULT !== 32'h0) begin n_fail++; $display("FAIL rst_mid_result: got %h expected 00000000", RESULT); end
        last_result = 32'h0;
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        logic [31:0] res1, res2;
        lat1 = -1; lat2 = -1; res1 = 'x; res2 = 'x;
        @(negedge CLK);
        START = 1'b1; FUNC3 = F3_MUL; OPERAND1 = 32'd3; OPERAND2 = 32'd5;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (DONE) begin
                lat1 = k; res1 = RESULT;
                FUNC3 = F3_DIVU; OPERAND1 = 32'd100; OPERAND2 = 32'd7;
                break;
            end
        end
        n_checks++; if (res1 !== 32'd15) begin n_fail++; $display("FAIL b2b_first_result: got %h expected 0000000f", res1); end
        n_checks++; if (lat1 != 3) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 3", lat1); end
        @(negedge CLK);
        START = 1'b0;
        n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL b2b_zero_gap: got busy %b expected 1", BUSY); end
        for (int k = 2; k <= 60; k++) begin
            @(negedge CLK);
            if (DONE) begin lat2 = k; res2 = RESULT; break; end
        end
        n_checks++; if (res2 !== 32'd14) begin n_fail++; $display("FAIL b2b_second_result: got %h expected 0000000e", res2); end
        n_checks++; if (lat2 != 34) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 34", lat2); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_special();
        test_flush();
        test_ignored_start();
        test_rst_mid();
        test_back_to_back();
        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
